// File: rtl/cistern_monitor.sv
// Cistern level monitor: per-switch sync + debounce, thermometer validation,
// hex display with fault code and alarms. Optional pump control: CISTERN_PUMP_CTRL_EN.
module cistern_monitor #(
  parameter int N_FLOATERS      = 8,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int FAULT_CYCLES    = 4,
  parameter int LOW_THRESH      = 1,
  parameter int HIGH_THRESH     = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_FLOATERS-1:0] floater,
  output logic [3:0]            level,
  output logic [3:0]            NumHex,
  output logic [6:0]            sseg,
  output logic                  fault,
  output logic                  alarm_low,
  output logic                  alarm_high,
  output logic                  level_chg
`ifdef CISTERN_PUMP_CTRL_EN
  ,
  output logic                  pump
`endif
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int FW = $clog2(FAULT_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0] FC_MAX  = FW'(FAULT_CYCLES);
  localparam logic [3:0]    LOW_L   = 4'(LOW_THRESH);
  localparam logic [3:0]    FULL_L  = 4'(N_FLOATERS);

  if (N_FLOATERS < 1 || N_FLOATERS > 15) begin : g_bad_n
    $error("cistern_monitor: N_FLOATERS must be in 1..15");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("cistern_monitor: DEBOUNCE_CYCLES must be >= 1");
  end
  if (FAULT_CYCLES < 1) begin : g_bad_fc
    $error("cistern_monitor: FAULT_CYCLES must be >= 1");
  end
  if (HIGH_THRESH <= LOW_THRESH) begin : g_bad_thresh
    $error("cistern_monitor: HIGH_THRESH must exceed LOW_THRESH");
  end

  logic [N_FLOATERS-1:0] r_sync1;
  logic [N_FLOATERS-1:0] r_sync2;
  logic [N_FLOATERS-1:0] w_filt;
  logic [N_FLOATERS-1:0] w_filt_inc;
  logic                  w_valid;
  logic [3:0]            w_popcnt;
  logic [3:0]            w_level_next;
  logic [3:0]            w_numhex_next;
  logic [FW-1:0]         w_fcnt_next;
  logic                  w_fault_next;

  logic [3:0]    r_level;
  logic [3:0]    r_numhex;
  logic [6:0]    r_sseg;
  logic [FW-1:0] r_fcnt;
  logic          r_fault;
  logic          r_alarm_low;
  logic          r_alarm_high;
  logic          r_level_chg;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= floater;
      r_sync2 <= r_sync1;
    end
  end

  // Each switch owns its counter; a change is accepted only after it has been
  // seen on DEBOUNCE_CYCLES consecutive samples.
  for (genvar gi = 0; gi < N_FLOATERS; gi++) begin : g_db
    logic [CW-1:0] r_cnt;
    logic          r_filt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt  <= '0;
        r_filt <= 1'b0;
      end else if (r_sync2[gi] == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        r_filt <= r_sync2[gi];
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_filt[gi] = r_filt;
  end

  // A thermometer code 0..01..1 has no set bit above its lowest zero, so
  // adding one clears every set bit (all-ones wraps to zero).
  assign w_filt_inc = w_filt + N_FLOATERS'(1);
  assign w_valid    = ((w_filt & w_filt_inc) == '0);

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < N_FLOATERS; i++) begin
      w_popcnt = w_popcnt + {3'b000, w_filt[i]};
    end
  end

  always_comb begin
    w_level_next = r_level;
    w_fcnt_next  = r_fcnt;
    w_fault_next = r_fault;
    if (w_valid) begin
      w_level_next = w_popcnt;
      w_fcnt_next  = '0;
      w_fault_next = 1'b0;
    end else begin
      if (r_fcnt != FC_MAX) begin
        w_fcnt_next = r_fcnt + 1'b1;
      end
      if (w_fcnt_next == FC_MAX) begin
        w_fault_next = 1'b1;
      end
    end
  end

  assign w_numhex_next = w_fault_next ? 4'hE : w_level_next;

  // Display and alarms are registered from the next-state values so they move
  // on the same edge as level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level      <= '0;
      r_fcnt       <= '0;
      r_fault      <= 1'b0;
      r_numhex     <= 4'h0;
      r_sseg       <= 7'b1000000;
      r_alarm_low  <= 1'b1;
      r_alarm_high <= 1'b0;
      r_level_chg  <= 1'b0;
    end else begin
      r_level      <= w_level_next;
      r_fcnt       <= w_fcnt_next;
      r_fault      <= w_fault_next;
      r_numhex     <= w_numhex_next;
      r_sseg       <= seg7(w_numhex_next);
      r_alarm_low  <= (w_level_next <= LOW_L);
      r_alarm_high <= (w_level_next == FULL_L);
      r_level_chg  <= (w_level_next != r_level);
    end
  end

  assign level      = r_level;
  assign NumHex     = r_numhex;
  assign sseg       = r_sseg;
  assign fault      = r_fault;
  assign alarm_low  = r_alarm_low;
  assign alarm_high = r_alarm_high;
  assign level_chg  = r_level_chg;

`ifdef CISTERN_PUMP_CTRL_EN
  localparam logic [3:0] HIGH_L = 4'(HIGH_THRESH);

  logic r_pump;
  logic w_pump_next;

  // Hysteresis between the two thresholds; a fault always stops the pump.
  always_comb begin
    w_pump_next = r_pump;
    if (w_fault_next) begin
      w_pump_next = 1'b0;
    end else if (w_level_next <= LOW_L) begin
      w_pump_next = 1'b1;
    end else if (w_level_next >= HIGH_L) begin
      w_pump_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pump <= 1'b0;
    end else begin
      r_pump <= w_pump_next;
    end
  end

  assign pump = r_pump;
`endif

endmodule
